// File: rtl/sync_fifo_parity.sv
// Single-clock FIFO that stores one parity bit per entry and checks it on
// every read; provides level flags plus sticky overflow/underflow/parity flags.
module sync_fifo_parity #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2,
  parameter int ODD_PARITY = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  err_inject,
  input  logic                  rd_en,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  parity_err,
  output logic                  parity_err_sticky
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C      = CW'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_C      = CW'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE_C = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C = ADDR_WIDTH'(1);
  localparam logic                  ODD_C     = (ODD_PARITY != 0) ? 1'b1 : 1'b0;

  function automatic logic parity_calc(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  logic [DATA_WIDTH:0]   mem_r [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r, rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r, count_next_s;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_valid_r, parity_err_r;
  logic                  full_r, empty_r, almost_full_r, almost_empty_r;
  logic                  overflow_r, underflow_r, parity_sticky_r;
  logic                  overflow_next_s, underflow_next_s, parity_sticky_next_s;
  logic                  wr_acc_s, rd_acc_s, rd_par_err_s;
  logic [DATA_WIDTH:0]   rd_entry_s;

  // Reads are gated by the registered empty flag, so an empty FIFO never falls through.
  assign wr_acc_s     = wr_en && (!full_r || rd_en);
  assign rd_acc_s     = rd_en && !empty_r;
  assign rd_entry_s   = mem_r[rd_ptr_r];
  assign rd_par_err_s = (parity_calc(rd_entry_s[DATA_WIDTH-1:0]) ^ ODD_C) != rd_entry_s[DATA_WIDTH];

  // Next occupancy and sticky error flags; a set event wins over err_clr.
  always_comb begin
    count_next_s         = count_r;
    overflow_next_s      = overflow_r;
    underflow_next_s     = underflow_r;
    parity_sticky_next_s = parity_sticky_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_next_s = count_r + CNT_ONE_C;
      2'b01:   count_next_s = count_r - CNT_ONE_C;
      default: count_next_s = count_r;
    endcase
    if (wr_en && !wr_acc_s) begin
      overflow_next_s = 1'b1;
    end else if (err_clr) begin
      overflow_next_s = 1'b0;
    end else begin
      overflow_next_s = overflow_r;
    end
    if (rd_en && !rd_acc_s) begin
      underflow_next_s = 1'b1;
    end else if (err_clr) begin
      underflow_next_s = 1'b0;
    end else begin
      underflow_next_s = underflow_r;
    end
    if (rd_acc_s && rd_par_err_s) begin
      parity_sticky_next_s = 1'b1;
    end else if (err_clr) begin
      parity_sticky_next_s = 1'b0;
    end else begin
      parity_sticky_next_s = parity_sticky_r;
    end
  end

  // Storage array, intentionally not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= {parity_calc(wr_data) ^ ODD_C ^ err_inject, wr_data};
    end
  end

  // Pointers, occupancy, level flags, read port and error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r        <= '0;
      rd_ptr_r        <= '0;
      count_r         <= '0;
      rd_data_r       <= '0;
      rd_valid_r      <= 1'b0;
      parity_err_r    <= 1'b0;
      full_r          <= 1'b0;
      empty_r         <= 1'b1;
      almost_full_r   <= 1'b0;
      almost_empty_r  <= 1'b1;
      overflow_r      <= 1'b0;
      underflow_r     <= 1'b0;
      parity_sticky_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (rd_acc_s) begin
        rd_ptr_r  <= rd_ptr_r + PTR_ONE_C;
        rd_data_r <= rd_entry_s[DATA_WIDTH-1:0];
      end
      rd_valid_r      <= rd_acc_s;
      parity_err_r    <= rd_acc_s && rd_par_err_s;
      count_r         <= count_next_s;
      // Flags are registered from the next count so they always match the count output.
      full_r          <= (count_next_s == DEPTH_C);
      empty_r         <= (count_next_s == '0);
      almost_full_r   <= (count_next_s >= AF_C);
      almost_empty_r  <= (count_next_s <= AE_C);
      overflow_r      <= overflow_next_s;
      underflow_r     <= underflow_next_s;
      parity_sticky_r <= parity_sticky_next_s;
    end
  end

  assign rd_data           = rd_data_r;
  assign rd_valid          = rd_valid_r;
  assign count             = count_r;
  assign full              = full_r;
  assign empty             = empty_r;
  assign almost_full       = almost_full_r;
  assign almost_empty      = almost_empty_r;
  assign overflow          = overflow_r;
  assign underflow         = underflow_r;
  assign parity_err        = parity_err_r;
  assign parity_err_sticky = parity_sticky_r;

endmodule

// File: tb/tb_sync_fifo_parity.sv
// Directed bench for sync_fifo_parity: a queue scoreboard holds written
// payloads and injected-error marks, popped when a read is expected.
module tb_sync_fifo_parity;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0, err_inject = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty;
  logic       overflow, underflow, parity_err, parity_err_sticky;
  logic [4:0] count;

  int total = 0;
  int bad = 0;

  logic [8:0] sb_q[$];
  int         m_count = 0;
  logic [7:0] m_last_rd = 8'h00;
  logic       m_ovf = 1'b0, m_udf = 1'b0, m_pst = 1'b0;

  sync_fifo_parity dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .err_inject(err_inject), .rd_en(rd_en), .err_clr(err_clr),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .parity_err(parity_err),
    .parity_err_sticky(parity_err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_levels();
    check("count", 32'(count), 32'(m_count));
    check("full", 32'(full), 32'(m_count == 16));
    check("empty", 32'(empty), 32'(m_count == 0));
    check("almost_full", 32'(almost_full), 32'(m_count >= 14));
    check("almost_empty", 32'(almost_empty), 32'(m_count <= 2));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_udf));
    check("parity_sticky", 32'(parity_err_sticky), 32'(m_pst));
  endtask

  // One clock cycle of stimulus; the model predicts acceptance from its own count.
  task automatic cyc(input logic w, input logic [7:0] d, input logic inj,
                     input logic r, input logic clr);
    logic       wacc, racc;
    logic [8:0] exp_e;
    wacc = w && ((m_count < 16) || r);
    racc = r && (m_count > 0);
    exp_e = 9'h000;
    wr_en = w; wr_data = d; err_inject = inj; rd_en = r; err_clr = clr;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; err_inject = 1'b0;
    if (racc) begin
      exp_e = sb_q.pop_front();
      m_last_rd = exp_e[7:0];
    end
    if (wacc) sb_q.push_back({inj, d});
    m_count = m_count + (wacc ? 1 : 0) - (racc ? 1 : 0);
    m_ovf = (w && !wacc) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_udf = (r && !racc) ? 1'b1 : (clr ? 1'b0 : m_udf);
    m_pst = (racc && exp_e[8]) ? 1'b1 : (clr ? 1'b0 : m_pst);
    check("rd_valid", 32'(rd_valid), 32'(racc));
    check("rd_data", 32'(rd_data), 32'(m_last_rd));
    check("parity_err", 32'(parity_err), 32'(racc && exp_e[8]));
    check_levels();
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_count = 0; m_last_rd = 8'h00;
    m_ovf = 1'b0; m_udf = 1'b0; m_pst = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check_levels();
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 0x00..0x0F, then a rejected 17th write
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    // Full with simultaneous read and write: both accepted, no overflow
    cyc(1'b1, 8'h10, 1'b0, 1'b1, 1'b0);
    // Drain everything in order
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    // Read on empty, then err_clr in the same cycle as another rejected read
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    // Empty with simultaneous read and write: write only, underflow set
    cyc(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

    // Error injection on 0xA5, sticky holds until err_clr
    cyc(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Wrap-around with count kept between 1 and 15
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic w, r;
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (m_count >= 15) w = 1'b0;
      if (m_count <= 1) r = 1'b0;
      if (!w && !r) begin w = 1'b1; r = 1'b1; end
      cyc(w, 8'($urandom), 1'b0, r, 1'b0);
    end
    while (m_count > 0) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Async reset mid-cycle with count=5 and underflow set
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_rd_valid", 32'(rd_valid), 32'd0);
    check("arst_rd_data", 32'(rd_data), 32'd0);
    check("arst_parity_err", 32'(parity_err), 32'd0);
    check_levels();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 8'h69, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
